// File: rtl/pulse_burst_counter_pkg.sv
// Shared types and default parameters for the pulse measurement blocks.
package pulse_meas_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int unsigned DEF_WINDOW      = 16;
  localparam int unsigned DEF_CNT_W       = 8;
  localparam int unsigned DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/pulse_burst_counter_if.sv
// Result handshake between the burst counter and its consumer.
interface pulse_burst_counter_if
  import pulse_meas_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) ();

  logic [CNT_W-1:0] count_out;
  logic             count_valid;
  logic             count_ready;

  modport master (output count_out, output count_valid, input count_ready);
  modport slave  (input count_out, input count_valid, output count_ready);

endinterface

// File: rtl/pulse_burst_counter_edge_sync.sv
// pulse_edge_sync: synchronizer, optional deglitch filter (PULSE_DEGLITCH_EN)
// and a registered one-cycle rising-edge strobe.
module pulse_edge_sync
  import pulse_meas_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic pulse_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic                   rise_q, rise_d;
  logic                   lvl;

`ifdef PULSE_DEGLITCH_EN
  logic samp_q, samp_d;
  logic filt_q, filt_d;

  // Filtered level follows the synced level only after two matching samples.
  always_comb begin
    samp_d = sync_q[SYNC_STAGES-1];
    filt_d = filt_q;
    if (sync_q[SYNC_STAGES-1] == samp_q) begin
      filt_d = sync_q[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      samp_q <= 1'b0;
      filt_q <= 1'b0;
    end else begin
      samp_q <= samp_d;
      filt_q <= filt_d;
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = sync_q[SYNC_STAGES-1];
`endif

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pulse_in};
    hist_d = lvl;
    rise_d = lvl & ~hist_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
      rise_q <= rise_d;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/pulse_burst_counter.sv
// Counts synchronized pulse_in rising edges over fixed windows and offers each
// window's count on a valid/ready handshake. PULSE_DEGLITCH_EN adds a glitch filter.
module pulse_burst_counter
  import pulse_meas_pkg::*;
#(
  parameter int unsigned WINDOW      = DEF_WINDOW,
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic                         pulse_in,
  pulse_burst_counter_if.master        res,
  output logic                         overrun,
  output logic                         active
);

  localparam int unsigned WIN_W = $clog2(WINDOW);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] count_out_q, count_out_d;
  logic             count_valid_q, count_valid_d;
  logic             overrun_q, overrun_d;
  logic             active_q, active_d;
  logic             rise;
  logic             xfer;
  logic             close;
  logic [CNT_W-1:0] acc_inc;

  pulse_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge_sync (
    .clk      (clk),
    .reset    (reset),
    .pulse_in (pulse_in),
    .rise     (rise)
  );

  assign xfer    = count_valid_q & res.count_ready;
  assign acc_inc = (rise && (acc_q != CNT_MAX)) ? acc_q + CNT_W'(1) : acc_q;

  // Window sequencing, result capture and handshake bookkeeping.
  always_comb begin
    state_d       = state_q;
    win_d         = win_q;
    acc_d         = acc_q;
    count_out_d   = count_out_q;
    count_valid_d = count_valid_q;
    overrun_d     = overrun_q;
    close         = 1'b0;

    unique case (state_q)
      IDLE: begin
        win_d = '0;
        acc_d = '0;
        if (en) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!en) begin
          // Abort: partial window is dropped, any pending result survives.
          state_d = IDLE;
          win_d   = '0;
          acc_d   = '0;
        end else if (win_q == WIN_W'(WINDOW - 1)) begin
          close         = 1'b1;
          win_d         = '0;
          acc_d         = '0;
          count_out_d   = acc_inc;
          count_valid_d = 1'b1;
          if (count_valid_q && !res.count_ready) begin
            overrun_d = 1'b1;
          end
        end else begin
          win_d = win_q + WIN_W'(1);
          acc_d = acc_inc;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (xfer && !close) begin
      count_valid_d = 1'b0;
    end

    active_d = (state_d == RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      win_q         <= '0;
      acc_q         <= '0;
      count_out_q   <= '0;
      count_valid_q <= 1'b0;
      overrun_q     <= 1'b0;
      active_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      win_q         <= win_d;
      acc_q         <= acc_d;
      count_out_q   <= count_out_d;
      count_valid_q <= count_valid_d;
      overrun_q     <= overrun_d;
      active_q      <= active_d;
    end
  end

  assign res.count_out   = count_out_q;
  assign res.count_valid = count_valid_q;
  assign overrun         = overrun_q;
  assign active          = active_q;

endmodule

// File: tb/tb_pulse_burst_counter.sv
// Randomized scoreboard bench for pulse_burst_counter against a window-level reference model.
module tb_pulse_burst_counter;
  import pulse_meas_pkg::*;

  localparam int unsigned WIN  = 20;
  localparam int unsigned CW   = 3;
  localparam int unsigned SS   = 2;
  localparam int          MAXV = (1 << CW) - 1;
`ifdef PULSE_DEGLITCH_EN
  localparam int DLY = SS + 2;
  localparam bit DG  = 1'b1;
`else
  localparam int DLY = SS + 1;
  localparam bit DG  = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic en = 1'b0;
  logic pulse_in = 1'b0;
  logic overrun;
  logic active;

  pulse_burst_counter_if #(.CNT_W(CW)) bus ();

  pulse_burst_counter #(
    .WINDOW      (WIN),
    .CNT_W       (CW),
    .SYNC_STAGES (SS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .pulse_in (pulse_in),
    .res      (bus.master),
    .overrun  (overrun),
    .active   (active)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: per-cycle samples of pulse_in, edge derived from a fixed
  // pipeline delay, windows counted with plain integers, results in a queue.
  bit pa [0:16383];
  bit fa [0:16383];
  int cyc;
  bit mrun, mvalid, movr;
  int mwin, macc;
  int q[$];

  function automatic bit lv(input int n);
    if (n < 0) return 1'b0;
    return DG ? fa[n] : pa[n];
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        cyc = 0; mrun = 0; mvalid = 0; movr = 0; mwin = 0; macc = 0;
        q.delete();
      end else begin
        bit e, xfer, close, pp, pf;
        pp = (cyc > 0) ? pa[cyc-1] : 1'b0;
        pf = (cyc > 0) ? fa[cyc-1] : 1'b0;
        pa[cyc] = pulse_in;
        fa[cyc] = (pulse_in == pp) ? pulse_in : pf;
        e = lv(cyc - DLY) & ~lv(cyc - DLY - 1);
        xfer = mvalid && bus.count_ready;
        close = 1'b0;
        if (!mrun) begin
          if (en) begin mrun = 1; mwin = 0; macc = 0; end
        end else if (!en) begin
          mrun = 0; mwin = 0; macc = 0;
        end else begin
          macc = (macc + int'(e) > MAXV) ? MAXV : macc + int'(e);
          if (mwin == WIN - 1) begin
            close = 1'b1;
            if (mvalid && !bus.count_ready && q.size() > 0) begin
              movr = 1'b1;
              q[q.size()-1] = macc;
            end else begin
              q.push_back(macc);
            end
            mvalid = 1'b1; macc = 0; mwin = 0;
          end else begin
            mwin++;
          end
        end
        if (xfer && !close) mvalid = 1'b0;
        cyc++;
      end
    end
  end

  // Monitor: compares DUT state on the falling edge and retires transferred results.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en && !reset) begin
        check("count_valid", int'(bus.count_valid), int'(mvalid));
        check("overrun", int'(overrun), int'(movr));
        check("active", int'(active), int'(mrun));
        if (mvalid && q.size() > 0) begin
          check("count_out", int'(bus.count_out), q[0]);
          if (bus.count_ready) void'(q.pop_front());
        end
      end
    end
  end

  // Stimulus state
  int hold = 1;
  int rdy_mode, en_mode, minh, maxh;

  task automatic step();
    @(posedge clk);
    #1;
    hold--;
    if (hold <= 0) begin
      pulse_in = ~pulse_in;
      hold = $urandom_range(maxh, minh);
    end
    case (rdy_mode)
      0: bus.count_ready = 1'b1;
      1: bus.count_ready = 1'($urandom_range(1, 0));
      default: bus.count_ready = 1'b0;
    endcase
    case (en_mode)
      0: en = 1'b1;
      1: if ($urandom_range(29, 0) == 0) en = ~en;
      default: en = 1'b0;
    endcase
  endtask

  task automatic run_phase(input int rm, input int em, input int lo, input int hi, input int n);
    rdy_mode = rm; en_mode = em; minh = lo; maxh = hi;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_count_out"}, int'(bus.count_out), 0);
    check({tag, "_count_valid"}, int'(bus.count_valid), 0);
    check({tag, "_overrun"}, int'(overrun), 0);
    check({tag, "_active"}, int'(active), 0);
  endtask

  initial begin
    bus.count_ready = 1'b1;
    minh = 2; maxh = 4;
    #1 reset = 1'b1;
    #11;
    check_reset_outputs("por");
    reset = 1'b0;
    chk_en = 1'b1;

    run_phase(0, 2, 2, 4, 10);   // idle: edges must be ignored
    run_phase(0, 0, 3, 3, 60);   // clean 3-high/3-low pulses, always ready
    run_phase(0, 0, 1, 2, 60);   // dense pulses, saturation
    run_phase(1, 0, 1, 4, 120);  // random ready, some close-with-ready
    run_phase(2, 0, 2, 5, 70);   // stalled consumer: overrun
    run_phase(0, 0, 2, 4, 30);   // drain after overrun
    run_phase(1, 1, 1, 4, 200);  // enable aborts

    // Reset in the middle of a run with a pending result.
    run_phase(2, 0, 2, 3, 1);
    begin
      int k = 0;
      while (!bus.count_valid && k < 200) begin step(); k++; end
      check("valid_before_reset", int'(bus.count_valid), 1);
    end
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    #12 reset = 1'b0;

    run_phase(0, 0, 1, 3, 80);
    for (int ph = 0; ph < 12; ph++) begin
      run_phase($urandom_range(2, 0), $urandom_range(1, 0), 1, $urandom_range(5, 2), $urandom_range(120, 40));
    end
    run_phase(0, 2, 2, 4, 10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
